fetch_pc_pipe: RTL and testbench
================================

# fetch_pc_pipe

Instruction-fetch datapath of the 5-stage RISC-V pipeline. Holds the program counter, computes PC+4, selects the next PC between the sequential address and the execute-stage branch/jump target, and registers the fetched instruction and its PCs into the IF/ID pipeline register. Instruction memory is external: the block drives `PCF` to it and receives `InstrF` combinationally.

## Interface
- `WIDTH`, 32, datapath width of PC and instruction words
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `clk` in 1: single clock; all state updates on the rising edge
- `reset` in 1: synchronous, active-high; one clock; reset is synchronous and active-high
- `PCSrcE` in 1: 1 = next PC is `PCTargetE` (taken branch/jump from Execute)
- `PCTargetE` in 32: branch/jump target from Execute
- `StallF` in 1: hold PC register
- `StallD` in 1: hold IF/ID register
- `FlushD` in 1: clear IF/ID register (insert bubble)
- `InstrF` in 32: instruction read from imem at `PCF`
- `PCF` out 32: current fetch PC (registered)
- `PCPlus4F` out 32: `PCF + 4` (combinational)
- `InstrD` out 32: registered instruction for Decode
- `PCD` out 32: registered PC for Decode
- `PCPlus4D` out 32: registered PC+4 for Decode

## Operation
- Adder: `PCPlus4F = PCF + 32'd4`, modulo 2^32; carry discarded (`32'hFFFF_FFFC + 4 = 0`).
- Next-PC mux: `PCNext = PCSrcE ? PCTargetE : PCPlus4F`. No alignment checking; target passes unmodified.
- PC register, per rising edge, priority order: `reset` -> `RESET_PC`; else `StallF` -> hold; else -> `PCNext`.
- IF/ID register (`InstrD`, `PCD`, `PCPlus4D` together), priority order: `reset` -> all zero; else `FlushD` -> all zero; else `StallD` -> hold; else load `InstrF`, `PCF`, `PCPlus4F`.
- Bubble encoding is all-zero (matches reset). Decode treats `InstrD == 0` as a no-op.
- `StallF` overrides `PCSrcE`. The hazard unit never asserts both in the same cycle; the block does not detect this case.
- `FlushD` overrides `StallD`.
- No internal state beyond the 32-bit PC and the 96-bit IF/ID register.

## Timing
- Reset values, after a rising edge with `reset=1`: `PCF=0x0`, `InstrD=0`, `PCD=0`, `PCPlus4D=0`. `PCPlus4F=0x4` combinationally.
- Reset is not seen until the clock edge. Reset asserted mid-run overrides stall, flush and `PCSrcE` at that edge.
- `PCF` changes only on rising edges. `PCPlus4F` follows `PCF` combinationally.
- Fetch-to-decode latency is one cycle: the instruction fetched at edge N appears on `InstrD` after edge N+1, with matching `PCD` and `PCPlus4D = PCD + 4`.
- Redirect: if `PCSrcE=1` is sampled at edge N (and `StallF=0`), then `PCF=PCTargetE` after edge N. Sequential flow resumes from the target.
- Back-to-back stalls hold values indefinitely. Release resumes with no lost or duplicated instruction.
- No combinational path from `InstrF` to any output.

## Test plan
- Reset then sequential run with imem model `Instr = f(PC)`: `PCF` steps 0, 4, 8, 12 on successive edges. `PCD` lags `PCF` by one cycle, `PCPlus4D = PCD + 4`, and `InstrD` equals the word at `PCD`.
- Taken branch: at `PCF=0x10`, pulse `PCSrcE=1`, `PCTargetE=0x40` for one cycle. Next `PCF=0x40`, then `0x44`. `PCD` becomes `0x10`, then `0x40`.
- Stall: assert `StallF=StallD=1` for 2 cycles at `PCF=0x8`. `PCF` holds `0x8` and `PCD` holds `0x4` for both cycles. After release, the sequence continues at `0xC` with no gap or duplicate.
- Flush: assert `FlushD=1` (plus `StallD=1`) for one edge. `InstrD`, `PCD` and `PCPlus4D` become 0 after that edge. `PCF` is unaffected.
- Wrap-around: set `PCSrcE=1`, `PCTargetE=0xFFFF_FFFC`. Next `PCF=0xFFFF_FFFC` with `PCPlus4F=0`. The following edge gives `PCF=0`.
- Mid-run reset: assert `reset` together with `PCSrcE=1`, `PCTargetE=0x80`. After the edge, `PCF=0` and the IF/ID outputs are 0. Outputs stay unchanged before the edge.

Source files
------------

// File: rtl/fetch_pc_pipe.sv
// fetch_pc_pipe: program counter, next-PC select and IF/ID pipeline register
module fetch_pc_pipe #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PCSrcE,
    input  logic [WIDTH-1:0] PCTargetE,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic [WIDTH-1:0] InstrF,
    output logic [WIDTH-1:0] PCF,
    output logic [WIDTH-1:0] PCPlus4F,
    output logic [WIDTH-1:0] InstrD,
    output logic [WIDTH-1:0] PCD,
    output logic [WIDTH-1:0] PCPlus4D
);
    logic [WIDTH-1:0] pc_q, pc_d, instr_q, instr_d, pcd_q, pcd_d, pc4d_q, pc4d_d;
    logic             clr_id, hold_id;
    assign PCPlus4F = pc_q + WIDTH'(4);
    assign clr_id   = reset || FlushD;
    assign hold_id  = StallD && !clr_id;
    always_comb begin
        pc_d    = reset ? RESET_PC : StallF ? pc_q : PCSrcE ? PCTargetE : PCPlus4F;
        instr_d = clr_id ? '0 : hold_id ? instr_q : InstrF;
        pcd_d   = clr_id ? '0 : hold_id ? pcd_q : pc_q;
        pc4d_d  = clr_id ? '0 : hold_id ? pc4d_q : PCPlus4F;
    end
    always_ff @(posedge clk) begin
        pc_q    <= pc_d;
        instr_q <= instr_d;
        pcd_q   <= pcd_d;
        pc4d_q  <= pc4d_d;
    end
    assign PCF      = pc_q;
    assign InstrD   = instr_q;
    assign PCD      = pcd_q;
    assign PCPlus4D = pc4d_q;
endmodule

// File: tb/tb_fetch_pc_pipe.sv
// tb_fetch_pc_pipe: directed plan plus random traffic against a behavioural fetch model
module tb_fetch_pc_pipe;
    logic        clk = 1'b0;
    logic        reset, PCSrcE, StallF, StallD, FlushD;
    logic [31:0] PCTargetE, InstrF, PCF, PCPlus4F, InstrD, PCD, PCPlus4D;
    logic [31:0] m_pc, m_i, m_pd, m_p4d;
    int          checks = 0;
    int          failures = 0;

    fetch_pc_pipe #(.WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .InstrF(InstrF),
        .PCF(PCF), .PCPlus4F(PCPlus4F), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign InstrF = imem(PCF);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model advances at the edge from the inputs held stable across it, then the DUT is compared at the falling edge.
    task automatic cycle();
        logic [31:0] opc;
        @(posedge clk);
        opc = m_pc;
        if (reset) begin
            m_pc = 32'h0; m_i = 0; m_pd = 0; m_p4d = 0;
        end else begin
            if (FlushD) begin
                m_i = 0; m_pd = 0; m_p4d = 0;
            end else if (!StallD) begin
                m_i = imem(opc); m_pd = opc; m_p4d = opc + 32'd4;
            end
            if (!StallF) m_pc = PCSrcE ? PCTargetE : opc + 32'd4;
        end
        @(negedge clk);
        chk("PCF", PCF, m_pc);
        chk("PCPlus4F", PCPlus4F, m_pc + 32'd4);
        chk("InstrD", InstrD, m_i);
        chk("PCD", PCD, m_pd);
        chk("PCPlus4D", PCPlus4D, m_p4d);
    endtask

    task automatic drive(input logic r, input logic src, input logic [31:0] tgt,
                         input logic sf, input logic sd, input logic fd);
        reset = r; PCSrcE = src; PCTargetE = tgt; StallF = sf; StallD = sd; FlushD = fd;
    endtask

    initial begin
        m_pc = 32'hDEAD_BEEF; m_i = 0; m_pd = 0; m_p4d = 0;
        drive(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        cycle();
        chk("rst_PCF", PCF, 32'h0);
        chk("rst_PCPlus4F", PCPlus4F, 32'h4);
        chk("rst_InstrD", InstrD, 32'h0);
        chk("rst_PCD", PCD, 32'h0);
        drive(0, 0, 0, 0, 0, 0);
        cycle();
        chk("seq_PCF4", PCF, 32'h4);
        chk("seq_InstrD0", InstrD, imem(32'h0));
        cycle();
        chk("seq_PCF8", PCF, 32'h8);
        chk("seq_PCD4", PCD, 32'h4);
        chk("seq_PCPlus4D8", PCPlus4D, 32'h8);
        drive(0, 0, 0, 1, 1, 0);
        repeat (2) begin
            cycle();
            chk("stall_PCF", PCF, 32'h8);
            chk("stall_PCD", PCD, 32'h4);
        end
        drive(0, 0, 0, 0, 0, 0);
        cycle();
        chk("rel_PCF", PCF, 32'hC);
        chk("rel_PCD", PCD, 32'h8);
        cycle();
        chk("pre_br_PCF", PCF, 32'h10);
        drive(0, 1, 32'h40, 0, 0, 0);
        cycle();
        chk("br_PCF", PCF, 32'h40);
        chk("br_PCD", PCD, 32'h10);
        drive(0, 0, 0, 0, 0, 0);
        cycle();
        chk("br_PCF44", PCF, 32'h44);
        chk("br_PCD40", PCD, 32'h40);
        drive(0, 0, 0, 0, 1, 1);
        cycle();
        chk("flush_PCF", PCF, 32'h48);
        chk("flush_InstrD", InstrD, 32'h0);
        chk("flush_PCD", PCD, 32'h0);
        chk("flush_PCPlus4D", PCPlus4D, 32'h0);
        drive(0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        cycle();
        chk("wrap_PCF", PCF, 32'hFFFF_FFFC);
        chk("wrap_PCPlus4F", PCPlus4F, 32'h0);
        drive(0, 0, 0, 0, 0, 0);
        cycle();
        chk("wrap_PCF0", PCF, 32'h0);
        chk("wrap_PCPlus4D", PCPlus4D, 32'h0);
        cycle();
        drive(1, 1, 32'h80, 0, 0, 0);
        #2;
        chk("mrst_pre_PCF", PCF, 32'h4);
        chk("mrst_pre_PCD", PCD, 32'h0);
        cycle();
        chk("mrst_PCF", PCF, 32'h0);
        chk("mrst_InstrD", InstrD, 32'h0);
        chk("mrst_PCD", PCD, 32'h0);
        for (int n = 0; n < 400; n++) begin
            logic src, sf;
            src = ($urandom_range(0, 5) == 0);
            sf  = !src && ($urandom_range(0, 4) == 0);
            drive($urandom_range(0, 49) == 0, src,
                  $urandom_range(0, 3) == 0 ? $urandom : ($urandom & 32'h0000_0FFC),
                  sf, $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0);
            cycle();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
